window_scanner: RTL and testbench

WINDOW_SCANNER -- requirements
Module: window_scanner

---
 rtl/canny_pkg.sv | 24 ++
 rtl/scan_coord.sv | 109 ++++++++++
 rtl/window_scanner.sv | 131 +++++++++++++
 tb/tb_window_scanner.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/canny_pkg.sv
// Shared definitions for the scanner and the 3x3 window buffer: shift
// direction encodings and the scanner FSM states.
package canny_pkg;

    typedef enum logic [1:0] {
        DIR_HOLD  = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_DOWN  = 2'b11
    } dir_t;

    typedef enum logic [2:0] {
        IDLE,
        RD0,
        RD1,
        RD2,
        PUSH,
        STEP,
        DONE
    } scan_state_t;

    localparam int PIX_W = 8;

endpackage

// File: rtl/scan_coord.sv
// Serpentine bookkeeping: window top-left, pending shift direction, priming
// progress, and the pixel address of each slot of the pending shift.
module scan_coord
    import canny_pkg::*;
#(
    parameter int IMG_W  = 16,
    parameter int IMG_H  = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_init,
    input  logic              i_accept,
    input  logic              i_step,
    input  logic [1:0]        i_slot,
    output logic [ADDR_W-1:0] o_addr,
    output dir_t              o_dir,
    output logic              o_last,
    output logic              o_win_fire,
    output logic [ADDR_W-1:0] o_cx,
    output logic [ADDR_W-1:0] o_cy
);

    localparam logic [ADDR_W-1:0] C_XMAX  = ADDR_W'(IMG_W - 3);
    localparam logic [ADDR_W-1:0] C_YMAX  = ADDR_W'(IMG_H - 3);
    localparam logic [ADDR_W-1:0] C_WIDTH = ADDR_W'(IMG_W);

    logic [ADDR_W-1:0] r_x;
    logic [ADDR_W-1:0] r_y;
    dir_t              r_dir;
    logic              r_left;
    logic [1:0]        r_prime_cnt;

    logic              w_primed;
    logic              w_row_left;
    logic              w_edge;
    logic [ADDR_W-1:0] w_slot;
    logic [ADDR_W-1:0] w_row;
    logic [ADDR_W-1:0] w_col;

    assign w_primed   = (r_prime_cnt == 2'd3);
    // A down shift flips the travel direction of the next band.
    assign w_row_left = (r_dir == DIR_DOWN) ? ~r_left : r_left;
    assign w_edge     = w_row_left ? (r_x == '0) : (r_x == C_XMAX);
    assign o_last     = w_primed && w_edge && (r_y == C_YMAX);
    assign o_win_fire = (r_prime_cnt >= 2'd2);
    assign o_dir      = r_dir;
    assign o_cx       = r_x + ADDR_W'(1);
    assign o_cy       = r_y + ADDR_W'(1);

    // Coordinates already describe the window the pending shift produces.
    always_comb begin
        w_slot = ADDR_W'(i_slot);
        w_row  = w_slot;
        w_col  = ADDR_W'(r_prime_cnt);
        if (w_primed) begin
            case (r_dir)
                DIR_LEFT: begin
                    w_row = r_y + w_slot;
                    w_col = r_x;
                end
                DIR_DOWN: begin
                    w_row = r_y + ADDR_W'(2);
                    w_col = r_x + w_slot;
                end
                default: begin
                    w_row = r_y + w_slot;
                    w_col = r_x + ADDR_W'(2);
                end
            endcase
        end
    end

    assign o_addr = w_row * C_WIDTH + w_col;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x         <= '0;
            r_y         <= '0;
            r_dir       <= DIR_HOLD;
            r_left      <= 1'b0;
            r_prime_cnt <= 2'd0;
        end else if (i_init) begin
            r_x         <= '0;
            r_y         <= '0;
            r_dir       <= DIR_RIGHT;
            r_left      <= 1'b0;
            r_prime_cnt <= 2'd0;
        end else begin
            if (i_accept && !w_primed) begin
                r_prime_cnt <= r_prime_cnt + 2'd1;
            end
            if (i_step && w_primed && !o_last) begin
                r_left <= w_row_left;
                if (w_edge) begin
                    r_dir <= DIR_DOWN;
                    r_y   <= r_y + ADDR_W'(1);
                end else if (w_row_left) begin
                    r_dir <= DIR_LEFT;
                    r_x   <= r_x - ADDR_W'(1);
                end else begin
                    r_dir <= DIR_RIGHT;
                    r_x   <= r_x + ADDR_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/window_scanner.sv
// Frame scanner feeding a 3x3 window buffer: reads three pixels per shift
// from memory and pushes them along a serpentine path over the image.
module window_scanner
    import canny_pkg::*;
#(
    parameter int IMG_W  = 16,
    parameter int IMG_H  = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [PIX_W-1:0]  mem_rd_data,
    input  logic              mem_rd_valid,
    input  logic              win_ready,
    output logic              shift_enable,
    output logic [1:0]        shift_direction,
    output logic [PIX_W-1:0]  buffer_input [0:2],
    output logic              win_valid,
    output logic [ADDR_W-1:0] win_x,
    output logic [ADDR_W-1:0] win_y,
    output logic              busy,
    output logic              done
);

    scan_state_t       r_state;
    scan_state_t       w_next;
    logic              r_pending;
    logic [PIX_W-1:0]  r_cap [0:2];
    logic              r_win_valid;
    logic [ADDR_W-1:0] r_win_x;
    logic [ADDR_W-1:0] r_win_y;

    logic              w_in_rd;
    logic              w_got;
    logic              w_accept;
    logic [1:0]        w_slot;
    logic [ADDR_W-1:0] w_addr;
    dir_t              w_dir;
    logic              w_last;
    logic              w_win_fire;
    logic [ADDR_W-1:0] w_cx;
    logic [ADDR_W-1:0] w_cy;

    scan_coord #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_coord (
        .clk        (clk),
        .rst        (rst),
        .i_init     ((r_state == IDLE) && start),
        .i_accept   (w_accept),
        .i_step     (r_state == STEP),
        .i_slot     (w_slot),
        .o_addr     (w_addr),
        .o_dir      (w_dir),
        .o_last     (w_last),
        .o_win_fire (w_win_fire),
        .o_cx       (w_cx),
        .o_cy       (w_cy)
    );

    always_comb begin
        case (r_state)
            RD1:     w_slot = 2'd1;
            RD2:     w_slot = 2'd2;
            default: w_slot = 2'd0;
        endcase
    end

    assign w_in_rd  = (r_state == RD0) || (r_state == RD1) || (r_state == RD2);
    // The request goes out on the first cycle of a read state only; data is
    // accepted only while that request is outstanding.
    assign w_got    = w_in_rd && r_pending && mem_rd_valid;
    assign w_accept = (r_state == PUSH) && win_ready;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (start) w_next = RD0;
            RD0:  if (w_got) w_next = RD1;
            RD1:  if (w_got) w_next = RD2;
            RD2:  if (w_got) w_next = PUSH;
            PUSH: if (win_ready) w_next = STEP;
            STEP: w_next = w_last ? DONE : RD0;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_pending   <= 1'b0;
            r_win_valid <= 1'b0;
            r_win_x     <= '0;
            r_win_y     <= '0;
            for (int i = 0; i < 3; i++) r_cap[i] <= '0;
        end else begin
            r_state <= w_next;
            if (mem_rd_req) begin
                r_pending <= 1'b1;
            end else if (w_got) begin
                r_pending <= 1'b0;
            end
            for (int i = 0; i < 3; i++) begin
                if (w_got && (w_slot == 2'(i))) r_cap[i] <= mem_rd_data;
            end
            r_win_valid <= w_accept && w_win_fire;
            if (w_accept && w_win_fire) begin
                r_win_x <= w_cx;
                r_win_y <= w_cy;
            end
        end
    end

    assign mem_rd_req      = w_in_rd && !r_pending;
    assign mem_addr        = mem_rd_req ? w_addr : '0;
    assign shift_enable    = (r_state == PUSH);
    assign shift_direction = shift_enable ? w_dir : DIR_HOLD;
    assign buffer_input    = r_cap;
    assign win_valid       = r_win_valid;
    assign win_x           = r_win_x;
    assign win_y           = r_win_y;
    assign busy            = (r_state != IDLE);
    assign done            = (r_state == DONE);

endmodule

// File: tb/tb_window_scanner.sv
// Bench for window_scanner: a 4x4 and a 16x16 instance driven by a memory
// model, compared against a serpentine window-list reference.
module tb_window_scanner;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- 4x4 instance ----------------
    logic       start4 = 1'b0;
    logic       req4;
    logic [7:0] addr4;
    logic [7:0] d4 = 8'h00;
    logic       v4 = 1'b0;
    logic       spur4 = 1'b0;
    logic       rd_valid4;
    logic [7:0] rd_data4;
    logic       ready4;
    logic       force4 = 1'b0;
    logic       rmode4 = 1'b0;
    logic       rnd4 = 1'b1;
    logic       se4;
    logic [1:0] sd4;
    logic [7:0] bi4 [0:2];
    logic       wv4;
    logic [7:0] wx4, wy4;
    logic       busy4, done4;
    logic [7:0] img4 [0:15];
    int         lat4 = 1;

    assign rd_valid4 = v4 | spur4;
    assign rd_data4  = spur4 ? 8'hA5 : d4;
    assign ready4    = force4 ? 1'b0 : (rmode4 ? rnd4 : 1'b1);

    window_scanner #(.IMG_W(4), .IMG_H(4), .ADDR_W(8)) u4 (
        .clk(clk), .rst(rst), .start(start4),
        .mem_rd_req(req4), .mem_addr(addr4), .mem_rd_data(rd_data4), .mem_rd_valid(rd_valid4),
        .win_ready(ready4), .shift_enable(se4), .shift_direction(sd4), .buffer_input(bi4),
        .win_valid(wv4), .win_x(wx4), .win_y(wy4), .busy(busy4), .done(done4)
    );

    // ---------------- 16x16 instance ----------------
    logic       start16 = 1'b0;
    logic       req16;
    logic [7:0] addr16;
    logic [7:0] d16 = 8'h00;
    logic       v16 = 1'b0;
    logic       ready16;
    logic       rnd16 = 1'b1;
    logic       se16;
    logic [1:0] sd16;
    logic [7:0] bi16 [0:2];
    logic       wv16;
    logic [7:0] wx16, wy16;
    logic       busy16, done16;
    logic [7:0] img16 [0:255];
    int         lat16 = 1;

    assign ready16 = rnd16;

    window_scanner u16 (
        .clk(clk), .rst(rst), .start(start16),
        .mem_rd_req(req16), .mem_addr(addr16), .mem_rd_data(d16), .mem_rd_valid(v16),
        .win_ready(ready16), .shift_enable(se16), .shift_direction(sd16), .buffer_input(bi16),
        .win_valid(wv16), .win_x(wx16), .win_y(wy16), .busy(busy16), .done(done16)
    );

    // ---------------- memory models and ready randomisers ----------------
    int cnt4 = 0, cnt16 = 0;
    logic [7:0] pd4, pd16;

    always @(posedge clk) begin
        v4 <= 1'b0;
        if (cnt4 > 0) begin
            cnt4 = cnt4 - 1;
            if (cnt4 == 0) begin v4 <= 1'b1; d4 <= pd4; end
        end
        if (req4) begin
            pd4 = img4[addr4[3:0]];
            if (lat4 <= 1) begin v4 <= 1'b1; d4 <= pd4; end
            else cnt4 = lat4 - 1;
        end
        rnd4 <= 1'($urandom_range(0, 1));
    end

    always @(posedge clk) begin
        v16 <= 1'b0;
        if (cnt16 > 0) begin
            cnt16 = cnt16 - 1;
            if (cnt16 == 0) begin v16 <= 1'b1; d16 <= pd16; end
        end
        if (req16) begin
            pd16 = img16[addr16];
            if (lat16 <= 1) begin v16 <= 1'b1; d16 <= pd16; end
            else cnt16 = lat16 - 1;
        end
        rnd16 <= 1'($urandom_range(0, 1));
    end

    // ---------------- monitors ----------------
    logic [25:0] obs_sh4[$], obs_sh16[$];
    logic [15:0] obs_win4[$], obs_win16[$];
    int ndone4 = 0, ndone16 = 0;
    int proto_err = 0;
    bit out4 = 0, out16 = 0;
    bit pe4 = 0, pr4 = 0, pe16 = 0, pr16 = 0;
    logic [25:0] pv4, pv16;

    always @(negedge clk) begin
        if (rst) begin
            out4 = 0; pe4 = 0;
        end else begin
            if (se4 && ready4) obs_sh4.push_back({sd4, bi4[0], bi4[1], bi4[2]});
            if (!se4 && sd4 != 2'b00) proto_err++;
            if (pe4 && !pr4 && !(se4 && {sd4, bi4[0], bi4[1], bi4[2]} == pv4)) proto_err++;
            pe4 = se4; pr4 = ready4; pv4 = {sd4, bi4[0], bi4[1], bi4[2]};
            if (wv4) obs_win4.push_back({wx4, wy4});
            if (done4) ndone4++;
            if (rd_valid4) out4 = 0;
            if (req4) begin
                if (out4) proto_err++;
                out4 = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            out16 = 0; pe16 = 0;
        end else begin
            if (se16 && ready16) obs_sh16.push_back({sd16, bi16[0], bi16[1], bi16[2]});
            if (!se16 && sd16 != 2'b00) proto_err++;
            if (pe16 && !pr16 && !(se16 && {sd16, bi16[0], bi16[1], bi16[2]} == pv16)) proto_err++;
            pe16 = se16; pr16 = ready16; pv16 = {sd16, bi16[0], bi16[1], bi16[2]};
            if (wv16) obs_win16.push_back({wx16, wy16});
            if (done16) ndone16++;
            if (v16) out16 = 0;
            if (req16) begin
                if (out16) proto_err++;
                out16 = 1;
            end
        end
    end

    // ---------------- reference model ----------------
    logic [25:0] exp_sh[$];
    logic [15:0] exp_win[$];

    function automatic logic [7:0] pix(bit big, int a);
        return big ? img16[a] : img4[a];
    endfunction

    // Window list in serpentine order; each shift is the difference between
    // consecutive windows, after three priming columns.
    task automatic build_model(bit big, int W, int H);
        int wxq[$];
        int wyq[$];
        exp_sh.delete();
        exp_win.delete();
        for (int c = 0; c < 3; c++)
            exp_sh.push_back({2'b01, pix(big, c), pix(big, W + c), pix(big, 2 * W + c)});
        for (int b = 0; b <= H - 3; b++)
            for (int k = 0; k <= W - 3; k++) begin
                wxq.push_back((b % 2 == 0) ? k : W - 3 - k);
                wyq.push_back(b);
            end
        for (int i = 0; i < wxq.size(); i++) begin
            int x = wxq[i];
            int y = wyq[i];
            exp_win.push_back({8'(x + 1), 8'(y + 1)});
            if (i > 0) begin
                if (y != wyq[i-1])
                    exp_sh.push_back({2'b11, pix(big, (y + 2) * W + x), pix(big, (y + 2) * W + x + 1),
                                      pix(big, (y + 2) * W + x + 2)});
                else if (x > wxq[i-1])
                    exp_sh.push_back({2'b01, pix(big, y * W + x + 2), pix(big, (y + 1) * W + x + 2),
                                      pix(big, (y + 2) * W + x + 2)});
                else
                    exp_sh.push_back({2'b10, pix(big, y * W + x), pix(big, (y + 1) * W + x),
                                      pix(big, (y + 2) * W + x)});
            end
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(bit big);
        if (big) begin
            obs_sh16.delete(); obs_win16.delete(); ndone16 = 0;
            start16 = 1'b1; tick(); start16 = 1'b0;
        end else begin
            obs_sh4.delete(); obs_win4.delete(); ndone4 = 0;
            start4 = 1'b1; tick(); start4 = 1'b0;
        end
    endtask

    task automatic wait_done(string tag, bit big, int budget);
        int n = 0;
        while (((big ? ndone16 : ndone4) == 0) && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_timeout"}, 32'(n < budget), 1);
        repeat (6) tick();
    endtask

    task automatic compare_frame(string tag, bit big);
        int ns = big ? obs_sh16.size() : obs_sh4.size();
        int nw = big ? obs_win16.size() : obs_win4.size();
        chk({tag, "_nshift"}, ns, exp_sh.size());
        chk({tag, "_nwin"}, nw, exp_win.size());
        chk({tag, "_ndone"}, big ? ndone16 : ndone4, 1);
        chk({tag, "_busy_end"}, big ? busy16 : busy4, 0);
        chk({tag, "_protocol"}, proto_err, 0);
        for (int i = 0; i < exp_sh.size(); i++)
            chk($sformatf("%s_sh%0d", tag, i), big ? obs_sh16[i] : obs_sh4[i], exp_sh[i]);
        for (int i = 0; i < exp_win.size(); i++)
            chk($sformatf("%s_win%0d", tag, i), big ? obs_win16[i] : obs_win4[i], exp_win[i]);
    endtask

    task automatic check_idle4(string tag);
        chk({tag, "_req"}, req4, 0);
        chk({tag, "_addr"}, addr4, 0);
        chk({tag, "_se"}, se4, 0);
        chk({tag, "_sd"}, sd4, 0);
        chk({tag, "_bi"}, {bi4[0], bi4[1], bi4[2]}, 0);
        chk({tag, "_wv"}, wv4, 0);
        chk({tag, "_wxy"}, {wx4, wy4}, 0);
        chk({tag, "_busy"}, busy4, 0);
        chk({tag, "_done"}, done4, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        int nreq;
        logic [25:0] held;

        for (int i = 0; i < 16; i++) img4[i] = 8'(i);
        for (int i = 0; i < 256; i++) img16[i] = 8'($urandom);
        repeat (3) tick();
        @(negedge clk);
        check_idle4("reset");
        chk("reset_busy16", busy16, 0);
        tick();
        rst = 1'b0;
        tick();

        // 4x4 image, pixel = address, always ready, 1-cycle memory
        lat4 = 1;
        build_model(0, 4, 4);
        start_frame(0);
        @(negedge clk);
        chk("A_busy", busy4, 1);
        wait_done("A", 0, 500);
        compare_frame("A", 0);
        chk("A_first", obs_sh4[0], {2'b01, 8'd0, 8'd4, 8'd8});
        chk("A_down", obs_sh4[4], {2'b11, 8'd13, 8'd14, 8'd15});
        chk("A_left", obs_sh4[5], {2'b10, 8'd4, 8'd8, 8'd12});
        chk("A_win2", obs_win4[2], {8'd2, 8'd2});
        chk("A_win3", obs_win4[3], {8'd1, 8'd2});

        // spurious valid in IDLE, start pulsed while busy
        for (int i = 0; i < 16; i++) img4[i] = 8'($urandom);
        lat4 = 2;
        build_model(0, 4, 4);
        spur4 = 1'b1; tick(); tick(); spur4 = 1'b0;
        tick();
        @(negedge clk);
        chk("B_idle_busy", busy4, 0);
        start_frame(0);
        repeat (20) tick();
        start4 = 1'b1; tick(); start4 = 1'b0;
        repeat (7) tick();
        start4 = 1'b1; tick(); start4 = 1'b0;
        wait_done("B", 0, 500);
        compare_frame("B", 0);

        // downstream stalls the first push for five cycles
        for (int i = 0; i < 16; i++) img4[i] = 8'($urandom);
        lat4 = 1;
        build_model(0, 4, 4);
        force4 = 1'b1;
        start_frame(0);
        n = 0;
        @(negedge clk);
        while (!se4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("C_reach_push", 32'(n < 100), 1);
        held = {sd4, bi4[0], bi4[1], bi4[2]};
        chk("C_held_first", held, exp_sh[0]);
        for (int k = 0; k < 4; k++) begin
            tick();
            @(negedge clk);
            chk($sformatf("C_hold_se%0d", k), se4, 1);
            chk($sformatf("C_hold_val%0d", k), {sd4, bi4[0], bi4[1], bi4[2]}, held);
        end
        tick();
        force4 = 1'b0;
        wait_done("C", 0, 500);
        compare_frame("C", 0);

        // 3-cycle memory latency with random ready
        for (int i = 0; i < 16; i++) img4[i] = 8'($urandom);
        lat4 = 3;
        rmode4 = 1'b1;
        build_model(0, 4, 4);
        start_frame(0);
        wait_done("D", 0, 1000);
        compare_frame("D", 0);
        rmode4 = 1'b0;

        // reset during the second read of the second shift
        lat4 = 2;
        start_frame(0);
        n = 0;
        nreq = 0;
        while (nreq < 2 && n < 200) begin
            @(negedge clk);
            if (obs_sh4.size() >= 1 && req4) nreq++;
            n++;
        end
        chk("E_reach_rd1", 32'(n < 200), 1);
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        check_idle4("E_rst");
        tick();
        rst = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        check_idle4("E_after");
        build_model(0, 4, 4);
        start_frame(0);
        wait_done("E", 0, 500);
        compare_frame("E", 0);

        // default 16x16 frame with random latency and ready
        lat16 = $urandom_range(1, 3);
        build_model(1, 16, 16);
        start_frame(1);
        wait_done("F", 1, 20000);
        compare_frame("F", 1);
        chk("F_nwin196", obs_win16.size(), 196);
        chk("F_nshift198", obs_sh16.size(), 198);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
